// File: rtl/imem_port_arbiter_if.sv
// Request/response bundle between the fetch unit, the data/loader port,
// the instruction-memory arbiter and the single-port memory array.
interface imem_port_arbiter_if #(
  parameter int MA_W = 10
);
  // Handshake: a requester raises req with its address/we/wdata and holds them
  // until ack. ack (and err, on a rejected access) is a 1-cycle pulse.
  // rvalid is a later 1-cycle pulse for successful reads only; rdata holds.
  logic            if_req;
  logic [31:0]     if_addr;
  logic            if_ack;
  logic            if_err;
  logic            if_rvalid;
  logic [31:0]     if_rdata;

  logic            d_req;
  logic            d_we;
  logic [31:0]     d_addr;
  logic [31:0]     d_wdata;
  logic            d_ack;
  logic            d_err;
  logic            d_rvalid;
  logic [31:0]     d_rdata;

  logic            mem_en;
  logic            mem_we;
  logic [MA_W-1:0] mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_err, if_rvalid, if_rdata,
    output d_ack, d_err, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_err, if_rvalid, if_rdata,
    input  d_ack, d_err, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between instruction fetch and
// the data/loader port; one access in flight, round-robin on ties.
module imem_port_arbiter #(
  parameter int MEM_WORDS = 1024,
  parameter int MA_W      = 10
) (
  input  logic                clk,
  input  logic                reset,
  imem_port_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [MA_W-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     d_rdata_q, d_rdata_d;

  logic            pick_d;
  logic [31:0]     sel_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_D;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    // Data wins only when fetch is idle or fetch was the last port served.
    pick_d      = bus.d_req && (!bus.if_req || last_q == OWN_IF);
    sel_addr    = pick_d ? bus.d_addr : bus.if_addr;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          owner_d = pick_d;
          last_d  = pick_d;
          we_d    = pick_d && bus.d_we;
          if (pick_d) wdata_d = bus.d_wdata;
          addr_d  = sel_addr[MA_W+1:2];
          err_d   = (sel_addr[1:0] != 2'b00) ||
                    (sel_addr[31:2] >= 30'(MEM_WORDS));
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = (err_q || we_q) ? IDLE : WAIT;
      end
      WAIT: begin
        if (owner_q == OWN_D) begin
          d_rdata_d  = bus.mem_rdata;
          d_rvalid_d = 1'b1;
        end else begin
          if_rdata_d  = bus.mem_rdata;
          if_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.if_ack    = (state_q == ISSUE) && (owner_q == OWN_IF);
  assign bus.d_ack     = (state_q == ISSUE) && (owner_q == OWN_D);
  assign bus.if_err    = bus.if_ack && err_q;
  assign bus.d_err     = bus.d_ack && err_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = (state_q == ISSUE) && !err_q;
  assign bus.mem_we    = bus.mem_en && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign dbg_state_o   = state_q;

endmodule
